// File: rtl/boot_ctrl.sv
// boot_ctrl: boot/halt controller that owns the core reset and muxes the memory port between core and host.
// Define BOOT_CTRL_HOLD_ON_RESET_EN to leave the core halted after reset until the host releases it.
module boot_ctrl #(
    parameter int AW    = 30,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt_req,
    output logic             halted,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [31:0]      host_data_w,
    input  logic [3:0]       host_mask_w,
    output logic             host_ack,
    output logic [31:0]      host_data_r,
    output logic             cpu_reset,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [31:0]      cpu_data_w,
    input  logic [3:0]       cpu_mask_w,
    output logic [AW-1:0]    mem_addr,
    output logic [31:0]      mem_data_w,
    output logic [3:0]       mem_mask_w,
    input  logic [31:0]      mem_data_r,
    output logic [CNT_W-1:0] run_count
);

    typedef enum logic [3:0] {
        S_RUN     = 4'b0001,
        S_HALT    = 4'b0010,
        S_ACK     = 4'b0100,
        S_RELEASE = 4'b1000
    } state_t;

`ifdef BOOT_CTRL_HOLD_ON_RESET_EN
    localparam state_t RST_STATE = S_HALT;
`else
    localparam state_t RST_STATE = S_RELEASE;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             host_sel;
    logic             host_wr;
    logic             ack_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RST_STATE;
            run_count <= '0;
        end else begin
            state     <= state_nxt;
            run_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = run_count;
        host_sel  = 1'b0;
        host_wr   = 1'b0;
        ack_c     = 1'b0;
        case (state)
            S_RUN: begin
                cnt_nxt = sat_inc(run_count);
                if (halt_req)
                    state_nxt = S_HALT;
            end
            S_HALT: begin
                host_sel = 1'b1;
                if (host_req) begin
                    host_wr   = host_we;
                    state_nxt = S_ACK;
                end else if (!halt_req) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RELEASE;
                end
            end
            S_ACK: begin
                // The write lane already fired in HALT; ACK only completes the handshake.
                host_sel  = 1'b1;
                ack_c     = 1'b1;
                state_nxt = S_HALT;
            end
            S_RELEASE: begin
                state_nxt = S_RUN;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    assign cpu_reset   = reset | (state != S_RUN);
    assign halted      = (state == S_HALT) | (state == S_ACK);
    assign host_ack    = ack_c & ~reset;
    assign host_data_r = mem_data_r;
    assign mem_addr    = host_sel ? host_addr : cpu_addr;
    assign mem_data_w  = host_sel ? host_data_w : cpu_data_w;

    // Reset overrides both sources so no lane can fire while the controller is being reset.
    always_comb begin
        mem_mask_w = 4'b0000;
        if (!reset) begin
            if (host_sel)
                mem_mask_w = host_wr ? host_mask_w : 4'b0000;
            else
                mem_mask_w = cpu_mask_w;
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: per-cycle vector table plus hand-written sequences for reset, saturation and release timing.
module tb_boot_ctrl;
    localparam int AW    = 30;
    localparam int CNT_W = 4;
`ifdef BOOT_CTRL_HOLD_ON_RESET_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam logic [31:0] CORE_DW = 32'h55AA55AA;

    logic             clock = 1'b0;
    logic             reset;
    logic             halt_req;
    logic             halted;
    logic             host_req;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [31:0]      host_data_w;
    logic [3:0]       host_mask_w;
    logic             host_ack;
    logic [31:0]      host_data_r;
    logic             cpu_reset;
    logic [AW-1:0]    cpu_addr;
    logic [31:0]      cpu_data_w;
    logic [3:0]       cpu_mask_w;
    logic [AW-1:0]    mem_addr;
    logic [31:0]      mem_data_w;
    logic [3:0]       mem_mask_w;
    logic [31:0]      mem_data_r;
    logic [CNT_W-1:0] run_count;

    logic [AW-1:0]    pc;
    logic [3:0]       core_mask;
    logic             mem_init;
    logic [31:0]      mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    boot_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .halt_req(halt_req), .halted(halted),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_data_w(host_data_w), .host_mask_w(host_mask_w), .host_ack(host_ack),
        .host_data_r(host_data_r), .cpu_reset(cpu_reset), .cpu_addr(cpu_addr),
        .cpu_data_w(cpu_data_w), .cpu_mask_w(cpu_mask_w), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_mask_w(mem_mask_w), .mem_data_r(mem_data_r),
        .run_count(run_count)
    );

    // Core stand-in: drives address 0 while held in reset, otherwise a fixed fetch address.
    assign cpu_addr   = cpu_reset ? '0 : pc;
    assign cpu_mask_w = core_mask;
    assign cpu_data_w = CORE_DW;

    // Single-port synchronous memory, read-before-write, byte-lane writes.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= {16'h1234, 8'h00, i[7:0]};
        end else begin
            mem_data_r <= mem[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_mask_w[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_data_w[8*b +: 8];
        end
    end

    typedef struct {
        logic        halt, hreq, hwe;
        logic [7:0]  haddr;
        logic [31:0] hdata;
        logic [3:0]  hmask, cmask;
        logic        e_crst, e_halted, e_ack;
        logic [3:0]  e_mask;
        logic [3:0]  e_cnt;
        logic [7:0]  e_addr;
        logic [31:0] e_dw;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic halt, input logic hreq, input logic hwe,
                                input logic [7:0] haddr, input logic [31:0] hdata,
                                input logic [3:0] hmask, input logic [3:0] cmask,
                                input logic e_crst, input logic e_halted, input logic e_ack,
                                input logic [3:0] e_mask, input logic [3:0] e_cnt,
                                input logic [7:0] e_addr, input logic [31:0] e_dw,
                                input logic chk_rd, input logic [31:0] e_rd);
        vec_t v;
        v.halt = halt; v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hdata = hdata;
        v.hmask = hmask; v.cmask = cmask; v.e_crst = e_crst; v.e_halted = e_halted;
        v.e_ack = e_ack; v.e_mask = e_mask; v.e_cnt = e_cnt; v.e_addr = e_addr;
        v.e_dw = e_dw; v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        //            halt hreq we addr  hdata         hm    cm    crst hl ack mask  cnt  addr  dw            rd  rdata
        tbl[0]  = mk(0, 0, 0, 8'h10, 32'h0,        4'h0, 4'h5, 0, 0, 0, 4'h5, 4'd0, 8'h40, CORE_DW,      0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 8'h10, 32'h0,        4'h0, 4'h0, 0, 0, 0, 4'h0, 4'd1, 8'h40, CORE_DW,      0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 8'h10, 32'h0,        4'h0, 4'hF, 1, 1, 0, 4'h0, 4'd2, 8'h10, 32'h0,        0, 32'h0);
        tbl[3]  = mk(1, 1, 1, 8'h10, 32'hDEADBEEF, 4'h3, 4'hF, 1, 1, 0, 4'h3, 4'd2, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        tbl[4]  = mk(1, 1, 1, 8'h10, 32'hDEADBEEF, 4'h3, 4'hF, 1, 1, 1, 4'h0, 4'd2, 8'h10, 32'hDEADBEEF, 0, 32'h0);
        tbl[5]  = mk(1, 1, 0, 8'h10, 32'h0,        4'hF, 4'h0, 1, 1, 0, 4'h0, 4'd2, 8'h10, 32'h0,        0, 32'h0);
        tbl[6]  = mk(1, 1, 0, 8'h10, 32'h0,        4'hF, 4'h0, 1, 1, 1, 4'h0, 4'd2, 8'h10, 32'h0,        1, 32'h1234BEEF);
        tbl[7]  = mk(1, 1, 0, 8'h11, 32'h0,        4'hF, 4'h0, 1, 1, 0, 4'h0, 4'd2, 8'h11, 32'h0,        0, 32'h0);
        tbl[8]  = mk(1, 1, 0, 8'h11, 32'h0,        4'hF, 4'h0, 1, 1, 1, 4'h0, 4'd2, 8'h11, 32'h0,        1, 32'h12340011);
        tbl[9]  = mk(0, 1, 1, 8'h12, 32'hCAFEF00D, 4'hC, 4'h0, 1, 1, 0, 4'hC, 4'd2, 8'h12, 32'hCAFEF00D, 0, 32'h0);
        tbl[10] = mk(0, 1, 1, 8'h12, 32'hCAFEF00D, 4'hC, 4'h0, 1, 1, 1, 4'h0, 4'd2, 8'h12, 32'hCAFEF00D, 0, 32'h0);
        tbl[11] = mk(0, 0, 0, 8'h12, 32'h0,        4'h0, 4'h0, 1, 1, 0, 4'h0, 4'd2, 8'h12, 32'h0,        0, 32'h0);
        tbl[12] = mk(0, 1, 1, 8'h13, 32'h0,        4'hF, 4'h0, 1, 0, 0, 4'h0, 4'd0, 8'h00, CORE_DW,      0, 32'h0);
        tbl[13] = mk(0, 1, 1, 8'h13, 32'h0,        4'hF, 4'h0, 0, 0, 0, 4'h0, 4'd0, 8'h40, CORE_DW,      0, 32'h0);
        tbl[14] = mk(0, 0, 0, 8'h13, 32'h0,        4'h0, 4'h0, 0, 0, 0, 4'h0, 4'd1, 8'h40, CORE_DW,      0, 32'h0);

        mem_init = 1'b1;
        reset = 1'b1;
        halt_req = HOLD;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_data_w = '0; host_mask_w = '0;
        pc = 30'h40;
        core_mask = 4'hF;

        step(); mem_init = 1'b0;
        step(); step();
        #1;
        chk("rst cpu_reset", cpu_reset, 1);
        chk("rst host_ack", host_ack, 0);
        chk("rst mem_mask_w", mem_mask_w, 0);
        chk("rst run_count", run_count, 0);
        chk("rst halted", halted, HOLD);

        reset = 1'b0;
        core_mask = 4'h0;
        #1;
        if (HOLD) begin
            for (int i = 0; i < 3; i++) begin
                step(); #1;
                chk($sformatf("hold%0d halted", i), halted, 1);
                chk($sformatf("hold%0d cpu_reset", i), cpu_reset, 1);
            end
            step(); halt_req = 1'b0; #1;
            chk("hold drop halted", halted, 1);
            step(); #1;
        end
        chk("release cpu_reset", cpu_reset, 1);
        chk("release halted", halted, 0);
        chk("release mem_addr", mem_addr, 0);

        for (int i = 0; i < 15; i++) begin
            step();
            halt_req = tbl[i].halt; host_req = tbl[i].hreq; host_we = tbl[i].hwe;
            host_addr = {22'b0, tbl[i].haddr}; host_data_w = tbl[i].hdata;
            host_mask_w = tbl[i].hmask; core_mask = tbl[i].cmask;
            #1;
            chk($sformatf("r%0d cpu_reset", i), cpu_reset, tbl[i].e_crst);
            chk($sformatf("r%0d halted", i), halted, tbl[i].e_halted);
            chk($sformatf("r%0d host_ack", i), host_ack, tbl[i].e_ack);
            chk($sformatf("r%0d mem_mask_w", i), mem_mask_w, tbl[i].e_mask);
            chk($sformatf("r%0d run_count", i), run_count, tbl[i].e_cnt);
            chk($sformatf("r%0d mem_addr", i), mem_addr, {22'b0, tbl[i].e_addr});
            chk($sformatf("r%0d mem_data_w", i), mem_data_w, tbl[i].e_dw);
            if (tbl[i].chk_rd) chk($sformatf("r%0d host_data_r", i), host_data_r, tbl[i].e_rd);
        end

        chk("mem[0x10] lanes", mem[8'h10], 32'h1234BEEF);
        chk("mem[0x12] lanes", mem[8'h12], 32'hCAFE0012);

        host_req = 1'b0; host_we = 1'b0; core_mask = 4'h0;
        for (int i = 0; i < 16; i++) begin
            step(); #1;
            chk($sformatf("sat%0d run_count", i), run_count, (2 + i > 15) ? 15 : 2 + i);
        end

        // halt_req raised while in RELEASE takes effect only from RUN
        step(); halt_req = 1'b1; #1;
        chk("rel0 halted", halted, 0);
        step(); halt_req = 1'b0; #1;
        chk("rel1 halted", halted, 1);
        chk("rel1 run_count held", run_count, 15);
        step(); halt_req = 1'b1; #1;
        chk("rel2 cpu_reset", cpu_reset, 1);
        chk("rel2 halted", halted, 0);
        chk("rel2 run_count", run_count, 0);
        step(); #1;
        chk("rel3 cpu_reset", cpu_reset, 0);
        chk("rel3 halted", halted, 0);
        step(); #1;
        chk("rel4 halted", halted, 1);
        chk("rel4 run_count", run_count, 1);

        // reset while the host write is in ACK
        step();
        host_req = 1'b1; host_we = 1'b1; host_addr = 30'h20;
        host_data_w = 32'h11223344; host_mask_w = 4'hF;
        #1;
        chk("rma write mask", mem_mask_w, 4'hF);
        step(); reset = 1'b1; #1;
        chk("rma host_ack", host_ack, 0);
        chk("rma mem_mask_w", mem_mask_w, 0);
        chk("rma cpu_reset", cpu_reset, 1);
        step(); reset = 1'b0; host_req = 1'b0; halt_req = HOLD; #1;
        chk("rma post halted", halted, HOLD);
        chk("rma post cpu_reset", cpu_reset, 1);
        chk("rma post run_count", run_count, 0);
        chk("rma mem kept", mem[8'h20], 32'h11223344);
        if (!HOLD) begin
            step(); #1;
            chk("rma run cpu_reset", cpu_reset, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
